acc_host_ctrl: RTL and testbench

Host-side initiator for the `accelerator` register interface. It takes a job trigger and a stream of N 32-bit IEEE-754 operands. It then:
- writes the operands to the accelerator at byte addresses 0,4,…,4(N-1);
- pulses `start` and polls `bsy` until the accelerator finishes;
- reads N results back and emits them as a valid/ready stream.

It replaces the hand-driven host sequence and sits between the system fabric and the accelerator.

---
 rtl/acc_host_pkg.sv | 32 +++
 rtl/acc_host_ctrl_if.sv | 47 ++++
 rtl/acc_host_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_acc_host_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_host_pkg.sv
// -----------------------------------------------------------------------------
// acc_host_pkg
// Shared definitions for the accelerator host controller:
//   - ACC_DATA_W      : operand / result width (IEEE-754 single, 32 bits)
//   - ACC_ADDR_STRIDE : byte distance between consecutive accelerator words
//   - acc_host_state_e: controller FSM state encoding
//   - word_addr()     : word index -> accelerator byte address
// -----------------------------------------------------------------------------
package acc_host_pkg;

    localparam int          ACC_DATA_W      = 32;
    localparam int unsigned ACC_ADDR_STRIDE = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_ARM,
        ST_WAIT,
        ST_RADDR,
        ST_RWAIT,
        ST_ROUT,
        ST_ERR
    } acc_host_state_e;

    // Accelerator words are packed back to back; upper address bits stay 0
    // because the index is always narrower than 30 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] idx);
        return idx * ACC_ADDR_STRIDE;
    endfunction

endpackage

// File: rtl/acc_host_ctrl_if.sv
// -----------------------------------------------------------------------------
// acc_host_ctrl_if
// Bundles every non-clock/reset signal of acc_host_ctrl.
//   Job control   : go, busy, done, err
//   Operand stream: in_valid, in_ready, in_data
//   Result stream : out_valid, out_ready, out_data
//   Accelerator   : acc_wen, acc_start, acc_addr, acc_din, acc_dout, acc_bsy
// Modports:
//   master - the host controller (drives the accelerator and the streams' control)
//   slave  - the surrounding fabric plus accelerator
// -----------------------------------------------------------------------------
interface acc_host_ctrl_if;
    import acc_host_pkg::*;

    logic                  go;
    logic                  busy;
    logic                  done;
    logic                  err;

    logic                  in_valid;
    logic                  in_ready;
    logic [ACC_DATA_W-1:0] in_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_DATA_W-1:0] out_data;

    logic                  acc_wen;
    logic                  acc_start;
    logic [31:0]           acc_addr;
    logic [ACC_DATA_W-1:0] acc_din;
    logic [ACC_DATA_W-1:0] acc_dout;
    logic                  acc_bsy;

    modport master (
        input  go, in_valid, in_data, out_ready, acc_dout, acc_bsy,
        output busy, done, err, in_ready, out_valid, out_data,
               acc_wen, acc_start, acc_addr, acc_din
    );

    modport slave (
        output go, in_valid, in_data, out_ready, acc_dout, acc_bsy,
        input  busy, done, err, in_ready, out_valid, out_data,
               acc_wen, acc_start, acc_addr, acc_din
    );

endinterface

// File: rtl/acc_host_ctrl.sv
// -----------------------------------------------------------------------------
// acc_host_ctrl
// Host-side initiator for the accelerator register interface. On go it
// accepts N operands and writes them to byte addresses 0,4,..,4(N-1), pulses
// acc_start, polls acc_bsy until the accelerator finishes, then reads N
// results back and emits them on a valid/ready stream, pulsing done when the
// last result is accepted.
//
// Parameters:
//   N           - words per job (1..64)
//   RD_LAT      - cycles from acc_addr change to valid acc_dout (>=1)
//   TIMEOUT_CYC - busy watchdog limit (only with ACC_HOST_TIMEOUT_EN)
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset
//   bus - acc_host_ctrl_if.master (job control, operand/result streams,
//         accelerator register port)
// Build option:
//   ACC_HOST_TIMEOUT_EN - when defined, a watchdog runs while waiting for the
//   accelerator; expiry sets the sticky err output and parks the FSM in ERR
//   until the next go. Undefined: no watchdog, err is constant 0.
// All outputs are registered.
// -----------------------------------------------------------------------------
module acc_host_ctrl
    import acc_host_pkg::*;
#(
    parameter int N           = 16,
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rst,
    acc_host_ctrl_if.master bus
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

    acc_host_state_e       state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [ACC_DATA_W-1:0] out_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  acc_wen_q;
    logic                  acc_start_q;
    logic [31:0]           acc_addr_q;
    logic [ACC_DATA_W-1:0] acc_din_q;

`ifdef ACC_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_q;
`else
    // The watchdog limit has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    logic in_hs;
    assign in_hs = bus.in_valid & in_ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            lat_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            acc_wen_q   <= 1'b0;
            acc_start_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_din_q   <= '0;
`ifdef ACC_HOST_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            // Single-cycle strobes default low; states re-assert them.
            acc_wen_q   <= 1'b0;
            acc_start_q <= 1'b0;
            done_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.go) begin
                        state_q    <= ST_LOAD;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (in_hs) begin
                        acc_wen_q  <= 1'b1;
                        acc_addr_q <= word_addr(32'(idx_q));
                        acc_din_q  <= bus.in_data;
                        if (idx_q == IDX_LAST) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_START;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end

                ST_START: begin
                    acc_start_q <= 1'b1;
                    state_q     <= ST_ARM;
`ifdef ACC_HOST_TIMEOUT_EN
                    to_q        <= '0;
`endif
                end

                // acc_start is on the port during this state; the
                // accelerator's bsy cannot be trusted until the next cycle.
                ST_ARM: begin
                    state_q <= ST_WAIT;
`ifdef ACC_HOST_TIMEOUT_EN
                    to_q    <= to_q + TO_W'(1);
`endif
                end

                ST_WAIT: begin
                    if (!bus.acc_bsy) begin
                        state_q <= ST_RADDR;
                        idx_q   <= '0;
                    end
`ifdef ACC_HOST_TIMEOUT_EN
                    else if (to_q >= TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= ST_ERR;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
`endif
                end

                ST_RADDR: begin
                    acc_addr_q <= word_addr(32'(idx_q));
                    lat_q      <= LAT_LOAD;
                    state_q    <= ST_RWAIT;
                end

                // The address became visible when this state was entered;
                // the counter reaches 0 on the cycle acc_dout is valid.
                ST_RWAIT: begin
                    if (lat_q == '0) begin
                        out_data_q  <= bus.acc_dout;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ROUT;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end

                // out_valid_q is 1 throughout this state, so out_ready alone
                // marks the handshake; data and address are held meanwhile.
                ST_ROUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == IDX_LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_RADDR;
                        end
                    end
                end

                // Only reachable through the watchdog; busy stays high.
                ST_ERR: begin
                    if (bus.go) begin
                        state_q    <= ST_LOAD;
                        idx_q      <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.acc_wen   = acc_wen_q;
    assign bus.acc_start = acc_start_q;
    assign bus.acc_addr  = acc_addr_q;
    assign bus.acc_din   = acc_din_q;

endmodule

// File: tb/tb_acc_host_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acc_host_ctrl
// Drives acc_host_ctrl against a cube-computing accelerator stub (RD_LAT=2).
// Expected results are pushed to a queue when each operand is accepted and
// popped when a result handshake is observed. With ACC_HOST_TIMEOUT_EN the
// watchdog is exercised with TIMEOUT_CYC=64.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acc_host_ctrl;

    localparam int N      = 16;
    localparam int RD_LAT = 2;
    localparam int TO_CYC =
`ifdef ACC_HOST_TIMEOUT_EN
        64;
`else
        4096;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_host_ctrl_if bus_if ();

    acc_host_ctrl #(
        .N          (N),
        .RD_LAT     (RD_LAT),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // 0.5, 2, 3 .. 16 and their cubes.
    logic [31:0] op_tab [16] = '{
        32'h3f000000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
    logic [31:0] cube_tab [16] = '{
        32'h3e000000, 32'h41000000, 32'h41d80000, 32'h42800000,
        32'h42fa0000, 32'h43580000, 32'h43ab8000, 32'h44000000,
        32'h44364000, 32'h447a0000, 32'h44a66000, 32'h44d80000,
        32'h45095000, 32'h452b8000, 32'h4552f000, 32'h45800000};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- accelerator stub: out = in^3 ----------------
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] o;
        o = $realtobits(r);
        if (o[62:0] == 63'd0) return {o[63], 31'd0};
        return {o[63], 8'(o[62:52] - 11'd896), o[51:29]};
    endfunction

    function automatic logic [31:0] f32_cube(input logic [31:0] f);
        real r;
        r = f32_to_real(f);
        return real_to_f32(r * r * r);
    endfunction

    logic [31:0] stub_mem [64];
    logic [31:0] stub_res [64];
    logic        stub_bsy   = 1'b0;
    logic [31:0] stub_dout  = 32'd0;
    int          stub_cnt   = 0;
    int          stub_bsy_len = 4;
    bit          stub_stuck = 1'b0;

    assign bus_if.acc_bsy  = stub_bsy;
    assign bus_if.acc_dout = stub_dout;

    always @(posedge clk) begin
        if (bus_if.acc_wen) stub_mem[bus_if.acc_addr[7:2]] <= bus_if.acc_din;
        if (bus_if.acc_start) begin
            stub_bsy <= 1'b1;
            stub_cnt <= stub_bsy_len;
            for (int i = 0; i < 64; i++) stub_res[i] <= 32'hdeadbeef;
        end else if (stub_bsy && !stub_stuck) begin
            if (stub_cnt <= 1) begin
                stub_bsy <= 1'b0;
                for (int i = 0; i < 64; i++) stub_res[i] <= f32_cube(stub_mem[i]);
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
        // One register stage: valid RD_LAT=2 cycles after acc_addr changes.
        stub_dout <= stub_res[bus_if.acc_addr[7:2]];
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] exp_q [$];
    int  cyc = 0;
    int  wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int  start_cyc = -1, first_ov_cyc = -1;
    bit  ov_seen = 1'b0;
    bit  prev_in_hs = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic [31:0] prev_in_data = '0, prev_od = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_in_hs = 1'b0;
            prev_ov    = 1'b0;
            prev_or    = 1'b0;
        end else begin
            if (bus_if.acc_wen || prev_in_hs) begin
                check_eq("wen_on_hs", 32'(bus_if.acc_wen), 32'(prev_in_hs));
                if (bus_if.acc_wen) begin
                    check_eq("wr_addr", bus_if.acc_addr, 32'(wr_cnt * 4));
                    check_eq("wr_data", bus_if.acc_din, prev_in_data);
                    wr_cnt++;
                end
            end
            if (bus_if.acc_start && start_cyc < 0) start_cyc = cyc;
            if (prev_ov && !prev_or) begin
                check_eq("hold_valid", 32'(bus_if.out_valid), 32'd1);
                check_eq("hold_data", bus_if.out_data, prev_od);
            end
            if (bus_if.out_valid) begin
                ov_seen = 1'b1;
                if (first_ov_cyc < 0) first_ov_cyc = cyc;
            end
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("out_data", bus_if.out_data, exp_q.pop_front());
                    check_eq("rd_addr", bus_if.acc_addr, 32'(rd_cnt * 4));
                end
                $display("OUT word=%0d data=%08h addr=%08h", rd_cnt, bus_if.out_data, bus_if.acc_addr);
                rd_cnt++;
            end
            if (bus_if.done) done_cnt++;
            prev_in_hs   = bus_if.in_valid && bus_if.in_ready;
            prev_in_data = bus_if.in_data;
            prev_ov      = bus_if.out_valid;
            prev_or      = bus_if.out_ready;
            prev_od      = bus_if.out_data;
        end
    end

    // ---------------- out_ready driver ----------------
    bit bp_mode   = 1'b0;
    bit hold_last = 1'b0;
    int low_left  = 0;

    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_last && rd_cnt == N - 1) begin
                bus_if.out_ready = 1'b0;
            end else if (bp_mode) begin
                if (low_left > 0) begin
                    bus_if.out_ready = 1'b0;
                    low_left--;
                end else begin
                    bus_if.out_ready = 1'b1;
                    if ($urandom_range(0, 2) == 0) low_left = $urandom_range(0, 5);
                end
            end else begin
                bus_if.out_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus tasks (called at posedge+1) ----------------
    task automatic clear_job();
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        start_cyc = -1; first_ov_cyc = -1; ov_seen = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_go();
        bus_if.go = 1'b1;
        @(posedge clk); #1;
        bus_if.go = 1'b0;
    endtask

    task automatic send_word(input int i, input int gap);
        int k;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = op_tab[i];
        k = 0;
        @(negedge clk);
        while (!bus_if.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("in_ready", 32'(bus_if.in_ready), 32'd1);
        exp_q.push_back(cube_tab[i]);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_start();
        for (int k = 0; k < 200 && start_cyc < 0; k++) @(negedge clk);
        check_eq("start_seen", 32'(start_cyc >= 0), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int gap, input bit noise, input bit do_go);
        if (do_go) begin
            clear_job();
            pulse_go();
        end
        check_eq("go_in_ready", 32'(bus_if.in_ready), 32'd1);
        hold_last = noise;
        for (int i = 0; i < N; i++) send_word(i, gap);
        if (noise) begin
            wait_start();
            repeat (5) @(posedge clk);
            #1;
            pulse_go();                        // during WAIT
            for (int k = 0; k < 3000 && !(bus_if.out_valid && rd_cnt == N - 1); k++)
                @(negedge clk);
            @(posedge clk); #1;
            bus_if.go = 1'b1;                  // during held ROUT
            @(posedge clk); #1;
            hold_last = 1'b0;                  // final handshake coincides with go
            @(posedge clk); #1;
            bus_if.go = 1'b0;
        end
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("done_once", 32'(done_cnt), 32'd1);
        check_eq("rd_count", 32'(rd_cnt), 32'(N));
        check_eq("wr_count", 32'(wr_cnt), 32'(N));
        check_eq("exp_left", 32'(exp_q.size()), 32'd0);
        check_eq("idle_busy", 32'(bus_if.busy), 32'd0);
        check_eq("idle_in_ready", 32'(bus_if.in_ready), 32'd0);
        check_eq("rd_after_bsy", 32'((first_ov_cyc - start_cyc) > stub_bsy_len), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({bus_if.busy, bus_if.in_ready, bus_if.out_valid, bus_if.done,
                                     bus_if.err, bus_if.acc_wen, bus_if.acc_start}), 32'd0);
        check_eq({tag, "_addr"}, bus_if.acc_addr, 32'd0);
        check_eq({tag, "_din"}, bus_if.acc_din, 32'd0);
        check_eq({tag, "_odata"}, bus_if.out_data, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus_if.go       = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // continuous operands, no backpressure
        run_job(0, 1'b0, 1'b1);
        // in_valid every other cycle
        run_job(1, 1'b0, 1'b1);
        // random out_ready bursts
        bp_mode = 1'b1;
        run_job(0, 1'b0, 1'b1);
        bp_mode = 1'b0;
        // long busy, go in WAIT/ROUT and with final handshake
        stub_bsy_len = 20;
        run_job(0, 1'b1, 1'b1);
        stub_bsy_len = 4;

        // reset in the middle of LOAD
        clear_job();
        pulse_go();
        for (int i = 0; i < 7; i++) send_word(i, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job(0, 1'b0, 1'b1);

`ifdef ACC_HOST_TIMEOUT_EN
        // watchdog: bsy stuck high
        stub_stuck = 1'b1;
        clear_job();
        pulse_go();
        for (int i = 0; i < N; i++) send_word(i, 0);
        for (int k = 0; k < 200 && start_cyc < 0; k++) @(negedge clk);
        check_eq("to_start_seen", 32'(start_cyc >= 0), 32'd1);
        for (int k = 0; k < 80 && !bus_if.err; k++) @(negedge clk);
        check_eq("to_err_set", 32'(bus_if.err), 32'd1);
        check_eq("to_err_lat", 32'((cyc - start_cyc) <= 66), 32'd1);
        repeat (10) @(negedge clk);
        check_eq("to_err_sticky", 32'(bus_if.err), 32'd1);
        check_eq("to_busy", 32'(bus_if.busy), 32'd1);
        check_eq("to_no_ov", 32'(ov_seen), 32'd0);
        stub_stuck = 1'b0;
        @(posedge clk); #1;
        clear_job();
        pulse_go();
        check_eq("to_err_clr", 32'(bus_if.err), 32'd0);
        run_job(0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
